truth_table_sweeper: RTL and testbench

Controller that characterises one 3-input combinational logic gate from the DNACompiler gate library. On `start` it drives all eight input vectors onto the gate in ascending order, waits a programmable settle time per vector, and samples the gate output. It assembles the measured 8-bit truth table and compares it against an expected table. It sits between a testbench or host sequencer and one gate instance, and owns the gate's input wires for the whole sweep.

---
 rtl/truth_table_sweeper.sv | 148 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps all 8 vectors through a 3-input gate and
// checks the measured truth table. Option macro: SWEEP_STOP_ON_FAIL_EN.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       dut_in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass,
  output logic [3:0] mismatch_count,
  output logic [2:0] fail_idx
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] CntLast = 8'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [2:0] idx_q;
  logic [7:0] cnt_q;
  logic [7:0] exp_q;
  logic [2:0] vec_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] tbl_q;
  logic       pass_q;
  logic [3:0] mc_q;
  logic [2:0] fi_q;

  logic [7:0] cnt_d;
  logic [3:0] mc_d;
  logic [2:0] idx_d;
  logic [7:0] tbl_d;
  logic       miss;

  // next-value helpers for the sample step
  always_comb begin
    cnt_d        = cnt_q + 8'd1;
    mc_d         = mc_q + 4'd1;
    idx_d        = idx_q + 3'd1;
    tbl_d        = tbl_q;
    tbl_d[idx_q] = dut_out;
    miss         = dut_out != exp_q[idx_q];
  end

  // sweep sequencer with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 8'd0;
      exp_q   <= 8'd0;
      vec_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tbl_q   <= 8'd0;
      pass_q  <= 1'b0;
      mc_q    <= 4'd0;
      fi_q    <= 3'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          vec_q  <= 3'd0;
          if (start) begin
            exp_q   <= expected;
            idx_q   <= 3'd0;
            cnt_q   <= 8'd0;
            tbl_q   <= 8'd0;
            mc_q    <= 4'd0;
            fi_q    <= 3'd0;
            pass_q  <= 1'b0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          busy_q <= 1'b1;
          if (cnt_q == 8'd0) begin
            vec_q <= idx_q;
          end
          if (cnt_q == CntLast) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        SAMPLE: begin
          busy_q <= 1'b1;
          tbl_q  <= tbl_d;
          cnt_q  <= 8'd0;
          if (miss) begin
            mc_q <= mc_d;
            if (mc_q == 4'd0) begin
              fi_q <= idx_q;
            end
          end
`ifdef SWEEP_STOP_ON_FAIL_EN
          if (miss || idx_q == 3'd7) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_d;
            state_q <= SETTLE;
          end
`else
          if (idx_q == 3'd7) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_d;
            state_q <= SETTLE;
          end
`endif
        end
        DONE: begin
          busy_q  <= 1'b0;
          vec_q   <= 3'd0;
          done_q  <= 1'b1;
          pass_q  <= tbl_q == exp_q;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dut_in1        = vec_q[2];
  assign dut_in2        = vec_q[1];
  assign dut_in3        = vec_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = tbl_q;
  assign pass           = pass_q;
  assign mismatch_count = mc_q;
  assign fail_idx       = fi_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed vector table plus hand sequences.
// Gate model is out = in2; instance A uses S=4, instance B uses S=1.
module tb_truth_table_sweeper;

  typedef struct {
    logic [7:0] exp;
    logic [7:0] tbl;
    logic       pass;
    logic [3:0] mc;
    logic [2:0] fi;
    int         cyc;
    bit         use_b;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] expected = 8'd0;

  logic       o_a, i1_a, i2_a, i3_a, busy_a, done_a, pass_a;
  logic [7:0] tbl_a;
  logic [3:0] mc_a;
  logic [2:0] fi_a;
  logic       o_b, i1_b, i2_b, i3_b, busy_b, done_b, pass_b;
  logic [7:0] tbl_b;
  logic [3:0] mc_b;
  logic [2:0] fi_b;

  bit         sel = 1'b0;
  logic       m_done, m_busy, m_pass;
  logic [7:0] m_tbl;
  logic [3:0] m_mc;
  logic [2:0] m_fi, m_vec;

  int nvec = 0;
  int nerr = 0;
  vec_t vecs[9];

  always #5 clk = ~clk;

  assign o_a = i2_a;
  assign o_b = i2_b;

  assign m_done = sel ? done_b : done_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_pass = sel ? pass_b : pass_a;
  assign m_tbl  = sel ? tbl_b : tbl_a;
  assign m_mc   = sel ? mc_b : mc_a;
  assign m_fi   = sel ? fi_b : fi_a;
  assign m_vec  = sel ? {i1_b, i2_b, i3_b} : {i1_a, i2_a, i3_a};

  truth_table_sweeper #(.SETTLE_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .expected(expected),
    .dut_out(o_a), .dut_in1(i1_a), .dut_in2(i2_a), .dut_in3(i3_a),
    .busy(busy_a), .done(done_a), .table_out(tbl_a), .pass(pass_a),
    .mismatch_count(mc_a), .fail_idx(fi_a)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(expected),
    .dut_out(o_b), .dut_in1(i1_b), .dut_in2(i2_b), .dut_in3(i3_b),
    .busy(busy_b), .done(done_b), .table_out(tbl_b), .pass(pass_b),
    .mismatch_count(mc_b), .fail_idx(fi_b)
  );

  task automatic check(input string name, input int act, input int want);
    nvec++;
    if (act != want) begin
      nerr++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               name, act, act, want, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input vec_t v, input bit mid);
    int s, n, last;
    bit seq_ok, busy_ok;
    sel = v.use_b;
    s = v.use_b ? 1 : 4;
    last = 8 * (s + 1);
    expected = v.exp;
    if (v.use_b) start_b = 1'b1;
    else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    n = 0;
    seq_ok = 1'b1;
    busy_ok = 1'b1;
    while (!m_done && n < 200) begin
      tick();
      n++;
      start_a = mid && (n == 9 || n == 19);
      if (n <= last) begin
        if (m_vec != 3'((n - 1) / (s + 1))) seq_ok = 1'b0;
        if (!m_busy) busy_ok = 1'b0;
      end
    end
    start_a = 1'b0;
    check("done_cycle", n, v.cyc);
    check("vec_sequence", int'(seq_ok), 1);
    check("busy_span", int'(busy_ok), 1);
    check("busy_at_done", int'(m_busy), 0);
    check("dut_in_idle", int'(m_vec), 0);
    check("table_out", int'(m_tbl), int'(v.tbl));
    check("pass", int'(m_pass), int'(v.pass));
    check("mismatch_count", int'(m_mc), int'(v.mc));
    check("fail_idx", int'(m_fi), int'(v.fi));
    tick();
    check("done_pulse_width", int'(m_done), 0);
    check("table_hold", int'(m_tbl), int'(v.tbl));
  endtask

  initial begin
    int n, d1, d2;
    bit saw;
    vecs[0] = '{8'hCC, 8'hCC, 1'b1, 4'd0, 3'd0, 41, 1'b0};
    vecs[1] = '{8'h33, 8'hCC, 1'b0, 4'd8, 3'd0, 41, 1'b0};
    vecs[2] = '{8'hC8, 8'hCC, 1'b0, 4'd1, 3'd2, 41, 1'b0};
    vecs[3] = '{8'hCD, 8'hCC, 1'b0, 4'd1, 3'd0, 41, 1'b0};
    vecs[4] = '{8'h4C, 8'hCC, 1'b0, 4'd1, 3'd7, 41, 1'b0};
    vecs[5] = '{8'h00, 8'hCC, 1'b0, 4'd4, 3'd2, 41, 1'b0};
    vecs[6] = '{8'hFF, 8'hCC, 1'b0, 4'd4, 3'd0, 41, 1'b0};
    vecs[7] = '{8'hCC, 8'hCC, 1'b1, 4'd0, 3'd0, 17, 1'b1};
    vecs[8] = '{8'hC8, 8'hCC, 1'b0, 4'd1, 3'd2, 17, 1'b1};

    repeat (3) tick();
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_table", int'(tbl_a), 0);
    check("rst_pass", int'(pass_a), 0);
    check("rst_mc", int'(mc_a), 0);
    check("rst_fi", int'(fi_a), 0);
    check("rst_vec", int'({i1_a, i2_a, i3_a}), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      sweep(vecs[i], 1'b0);
    end

    sweep(vecs[0], 1'b1);

    sel = 1'b0;
    expected = 8'hCC;
    start_a = 1'b1;
    tick();
    d1 = 0;
    d2 = 0;
    n = 0;
    while (d2 == 0 && n < 200) begin
      tick();
      n++;
      if (done_a && d1 == 0) d1 = n;
      else if (done_a) d2 = n;
      if (n == 42) begin
        check("retrig_cleared", int'(tbl_a), 0);
        start_a = 1'b0;
      end
      if (n == 43) check("retrig_busy", int'(busy_a), 1);
    end
    check("held_first_done", d1, 41);
    check("held_second_done", d2, 83);
    check("held_table", int'(tbl_a), 8'hCC);
    check("held_pass", int'(pass_a), 1);
    tick();

    expected = 8'hCC;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 17; k++) tick();
    check("pre_rst_table", int'(tbl_a), 8'h04);
    check("pre_rst_vec", int'({i1_a, i2_a, i3_a}), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_vec", int'({i1_a, i2_a, i3_a}), 0);
    check("midrst_table", int'(tbl_a), 0);
    check("midrst_done", int'(done_a), 0);
    saw = 1'b0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done_a || busy_a) saw = 1'b1;
    end
    check("midrst_no_done", int'(saw), 0);
    sweep(vecs[2], 1'b0);

    sel = 1'b0;
    rst = 1'b1;
    start_a = 1'b1;
    tick();
    rst = 1'b0;
    start_a = 1'b0;
    tick();
    check("rst_wins_busy", int'(busy_a), 0);
    tick();
    check("rst_wins_vec", int'({i1_a, i2_a, i3_a}), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
